// File: rtl/barrel_shift_pkg.sv
// Shared types and defaults for the barrel-shift scheduler: FSM states,
// requester-ID width and default datapath geometry.
package barrel_shift_pkg;

  localparam int ID_W         = 1;
  localparam int WIDTH_DEF    = 8;
  localparam int STEP_MAX_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/barrel_shift_sched_if.sv
// Two valid/ready request ports plus one backpressured result port.
// The master side is the requester/consumer; the slave side is the scheduler.
interface barrel_shift_sched_if
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = $clog2(WIDTH)
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [AMT_W-1:0] req0_amt;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [AMT_W-1:0] req1_amt;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [ID_W-1:0]  out_id;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req0_amt,
    output req1_valid, req1_data, req1_amt,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt,
    input  req1_valid, req1_data, req1_amt,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_id, busy
  );

endinterface

// File: rtl/barrel_rotate.sv
// Combinational left rotate by 0..STEP_MAX positions; only the step values
// the scheduler can issue get a mux leg.
module barrel_rotate #(
  parameter int WIDTH    = 8,
  parameter int AMT_W    = 3,
  parameter int STEP_MAX = 2
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] step,
  output logic [WIDTH-1:0] rotated
);

  always_comb begin
    // NOTE: default assignment first so every path drives rotated; no latch.
    rotated = data;
    for (int i = 1; i <= STEP_MAX; i++) begin
      if (int'(step) == i) begin
        rotated = (data << i) | (data >> (WIDTH - i));
      end
    end
  end

endmodule

// File: rtl/barrel_shift_sched.sv
// Round-robin scheduler sharing one iterative left-rotate datapath between
// two requesters; one operation in flight, result held until consumed.
module barrel_shift_sched
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int AMT_W    = $clog2(WIDTH),
  parameter int STEP_MAX = STEP_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  barrel_shift_sched_if.slave  bus
);

  state_t           state;
  logic             rr;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] step;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] rotated;
  logic             grant0;
  logic             grant1;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [ID_W-1:0]  out_id_q;
  logic             busy_q;

  // rr selects the winner only under contention; a sole requester always wins.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || !rr);
  assign grant1 = bus.req1_valid && (!bus.req0_valid ||  rr);

  // Readys are forced low while reset is held, independent of state.
  assign bus.req0_ready = reset && (state == IDLE) && grant0;
  assign bus.req1_ready = reset && (state == IDLE) && grant1;

  assign step = (int'(rem) > STEP_MAX) ? AMT_W'(STEP_MAX) : rem;

  barrel_rotate #(
    .WIDTH    (WIDTH),
    .AMT_W    (AMT_W),
    .STEP_MAX (STEP_MAX)
  ) u_rotate (
    .data    (work),
    .step    (step),
    .rotated (rotated)
  );

  // NOTE: sequential state uses <= so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr          <= 1'b0;
      rem         <= '0;
      work        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0_ready || bus.req1_ready) begin
            work     <= bus.req1_ready ? bus.req1_data : bus.req0_data;
            rem      <= bus.req1_ready ? bus.req1_amt  : bus.req0_amt;
            out_id_q <= bus.req1_ready;
            rr       <= !bus.req1_ready;
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          work <= rotated;
          rem  <= rem - step;
          // A zero amount still spends this one cycle with step 0.
          if (rem == step) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rotated;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_barrel_shift_sched.sv
// Self-checking bench: a transaction-level model (rotate arithmetic plus a
// shift-cycle countdown) is compared against the DUT every cycle.
module tb_barrel_shift_sched;
  import barrel_shift_pkg::*;

  localparam int W  = 8;
  localparam int AW = 3;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic rst;

  barrel_shift_sched_if #(.WIDTH(W), .AMT_W(AW)) bus  ();
  barrel_shift_sched_if #(.WIDTH(W), .AMT_W(AW)) bus1 ();

  barrel_shift_sched #(.WIDTH(W), .AMT_W(AW), .STEP_MAX(S)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  barrel_shift_sched #(.WIDTH(W), .AMT_W(AW), .STEP_MAX(1)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus, applied at each falling edge.
  logic       s_rst, s_v0, s_v1, s_ordy, s1_v0;
  logic [7:0] s_d0, s_d1, s1_d0;
  logic [2:0] s_a0, s_a1, s1_a0;

  // Behavioural model of the main instance.
  bit         m_busy, m_valid, m_rr, m_id;
  int         m_cnt;
  logic [7:0] m_data;
  int         acc_cnt = 0;
  int         acc_cyc = 0;
  int         res_q[$];

  // DUT samples taken 1 time unit after the falling edge.
  bit         smp_r0, smp_r1, smp_valid, smp_busy, smp_id;
  logic [7:0] smp_data;
  int         smp_cyc;
  bit         smp1_valid, acc1_seen;
  logic [7:0] smp1_data;
  int         acc1_cyc = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int rotl(input int d, input int a);
    return ((d << a) | (d >> (W - a))) & ((1 << W) - 1);
  endfunction

  function automatic int shift_cycles(input int a, input int step_max);
    return (a == 0) ? 1 : (a + step_max - 1) / step_max;
  endfunction

  task automatic cycle();
    bit want_r0, want_r1;
    int id, d, a;
    @(negedge clk);
    rst            = s_rst;
    bus.req0_valid = s_v0;
    bus.req0_data  = s_d0;
    bus.req0_amt   = s_a0;
    bus.req1_valid = s_v1;
    bus.req1_data  = s_d1;
    bus.req1_amt   = s_a1;
    bus.out_ready  = s_ordy;
    bus1.req0_valid = s1_v0;
    bus1.req0_data  = s1_d0;
    bus1.req0_amt   = s1_a0;
    #1;
    if (!s_rst) begin
      m_busy = 0; m_valid = 0; m_rr = 0; m_cnt = 0; m_data = 8'h00; m_id = 0;
    end
    want_r0 = s_rst && !m_busy && s_v0 && (!s_v1 || !m_rr);
    want_r1 = s_rst && !m_busy && s_v1 && (!s_v0 || m_rr);

    smp_r0 = bus.req0_ready;  smp_r1 = bus.req1_ready;
    smp_valid = bus.out_valid; smp_busy = bus.busy;
    smp_data = bus.out_data;  smp_id = bus.out_id[0];
    smp_cyc = cyc;
    smp1_valid = bus1.out_valid; smp1_data = bus1.out_data;
    if (bus1.req0_ready && s1_v0) begin
      acc1_seen = 1;
      acc1_cyc  = cyc + 1;
    end

    check("req0_ready", int'(smp_r0), int'(want_r0));
    check("req1_ready", int'(smp_r1), int'(want_r1));
    check("out_valid", int'(smp_valid), int'(m_valid));
    check("busy", int'(smp_busy), int'(m_busy));
    if (m_valid || !s_rst) begin
      check("out_data", int'(smp_data), int'(m_data));
      check("out_id", int'(smp_id), int'(m_id));
    end

    if (s_rst) begin
      if (!m_busy) begin
        if (want_r0 || want_r1) begin
          id = want_r1 ? 1 : 0;
          d  = id ? int'(s_d1) : int'(s_d0);
          a  = id ? int'(s_a1) : int'(s_a0);
          m_busy  = 1;
          m_cnt   = shift_cycles(a, S);
          m_data  = 8'(rotl(d, a));
          m_id    = id[0];
          m_rr    = !id[0];
          acc_cnt++;
          acc_cyc = cyc + 1;
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_valid = 1;
      end else if (s_ordy) begin
        res_q.push_back(int'(m_id) * 256 + int'(m_data));
        m_valid = 0;
        m_busy  = 0;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_single(input int n, input int d, input int a,
                            input int want_data, input int want_lat, input string tag);
    int a0;
    bit got;
    s_ordy = 1;
    if (n == 0) begin
      s_v0 = 1; s_d0 = 8'(d); s_a0 = 3'(a); s_v1 = 0;
    end else begin
      s_v1 = 1; s_d1 = 8'(d); s_a1 = 3'(a); s_v0 = 0;
    end
    a0  = acc_cnt;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = (acc_cnt != a0);
    end
    s_v0 = 0; s_v1 = 0;
    check({tag, "_accepted"}, int'(got), 1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = smp_valid;
    end
    check({tag, "_valid"}, int'(got), 1);
    check({tag, "_latency"}, smp_cyc - acc_cyc, want_lat);
    check({tag, "_data"}, int'(smp_data), want_data);
    check({tag, "_id"}, int'(smp_id), n);
  endtask

  task automatic drain();
    s_v0 = 0; s_v1 = 0; s_ordy = 1;
    for (int i = 0; i < 20 && m_busy; i++) cycle();
    check("drain_idle", int'(m_busy), 0);
  endtask

  initial begin
    int a0;
    bit got;
    rst = 1'b0;
    s_rst = 0; s_v0 = 0; s_v1 = 0; s_ordy = 1; s1_v0 = 0;
    s_d0 = 0; s_d1 = 0; s_a0 = 0; s_a1 = 0; s1_d0 = 0; s1_a0 = 0;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.out_ready = 1;
    bus.req0_data = 0; bus.req1_data = 0; bus.req0_amt = 0; bus.req1_amt = 0;
    bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.out_ready = 1;
    bus1.req0_data = 0; bus1.req1_data = 0; bus1.req0_amt = 0; bus1.req1_amt = 0;

    // Reset state, with requests pending.
    s_v0 = 1; s_v1 = 1;
    cycle();
    check("rst_req0_ready", int'(smp_r0), 0);
    check("rst_req1_ready", int'(smp_r1), 0);
    check("rst_out_valid", int'(smp_valid), 0);
    check("rst_busy", int'(smp_busy), 0);
    check("rst_out_data", int'(smp_data), 0);
    check("rst_out_id", int'(smp_id), 0);
    cycle();
    s_v0 = 0; s_v1 = 0; s_rst = 1;

    // Single requests, including zero and maximum amounts.
    run_single(0, 8'h81, 3, 8'h0C, 2, "amt3");
    run_single(1, 8'hA5, 0, 8'hA5, 1, "amt0");
    run_single(1, 8'h01, 7, 8'h80, 4, "amt7");

    // Contention from reset: strict alternation starting with requester 0.
    s_rst = 0; cycle(); cycle(); s_rst = 1;
    res_q.delete();
    s_v0 = 1; s_d0 = 8'h0F; s_a0 = 1;
    s_v1 = 1; s_d1 = 8'hF0; s_a1 = 2;
    s_ordy = 1;
    for (int i = 0; i < 100 && res_q.size() < 8; i++) cycle();
    s_v0 = 0; s_v1 = 0;
    check("contention_count", int'(res_q.size() >= 8), 1);
    for (int i = 0; i < res_q.size() && i < 8; i++)
      check("contention_result", res_q[i], (i % 2) ? (256 + 8'hC3) : 8'h1E);
    drain();

    // Backpressure: result held with both requesters waiting.
    s_ordy = 0;
    s_v0 = 1; s_d0 = 8'h3C; s_a0 = 5; s_v1 = 1; s_d1 = 8'h11; s_a1 = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = smp_valid;
    end
    check("bp_valid", int'(got), 1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_data", int'(smp_data), 8'h87);
      check("bp_id", int'(smp_id), 0);
      check("bp_ready0", int'(smp_r0), 0);
      check("bp_ready1", int'(smp_r1), 0);
      check("bp_busy", int'(smp_busy), 1);
    end
    s_v0 = 0; s_v1 = 0; s_ordy = 1;
    cycle();
    cycle();
    check("bp_released_valid", int'(smp_valid), 0);
    check("bp_released_busy", int'(smp_busy), 0);

    // Reset in the middle of a long rotate.
    s_v0 = 1; s_d0 = 8'h01; s_a0 = 7;
    a0 = acc_cnt;
    for (int i = 0; i < 10 && acc_cnt == a0; i++) cycle();
    s_v0 = 0;
    cycle();
    check("mid_busy", int'(smp_busy), 1);
    s_rst = 0;
    cycle();
    check("mid_rst_valid", int'(smp_valid), 0);
    check("mid_rst_busy", int'(smp_busy), 0);
    cycle();
    s_rst = 1;
    s_v0 = 1; s_d0 = 8'h55; s_a0 = 0; s_v1 = 1; s_d1 = 8'hAA; s_a1 = 0;
    cycle();
    check("rr_after_reset_r0", int'(smp_r0), 1);
    check("rr_after_reset_r1", int'(smp_r1), 0);
    drain();
    run_single(1, 8'h01, 1, 8'h02, 1, "post_reset");

    // Single-position-per-cycle build.
    s1_v0 = 1; s1_d0 = 8'h01; s1_a0 = 5; acc1_seen = 0;
    for (int i = 0; i < 10 && !acc1_seen; i++) cycle();
    s1_v0 = 0;
    check("step1_accepted", int'(acc1_seen), 1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = smp1_valid;
    end
    check("step1_valid", int'(got), 1);
    check("step1_latency", smp_cyc - acc1_cyc, 5);
    check("step1_data", int'(smp1_data), 8'h20);
    cycle();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      s_rst  = ($urandom_range(0, 199) != 0);
      s_v0   = 1'($urandom_range(0, 1));
      s_v1   = 1'($urandom_range(0, 1));
      s_d0   = 8'($urandom);
      s_d1   = 8'($urandom);
      s_a0   = 3'($urandom);
      s_a1   = 3'($urandom);
      s_ordy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    s_rst = 1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
